// File: rtl/cpu_wpost_bridge.sv
// -----------------------------------------------------------------------------
// CpuWpostBridge (top module cpu_wpost_bridge)
//
// Purpose:
//   Splits the CPU data port into two paths. Accesses outside the peripheral
//   window pass straight through to main memory. Writes inside the window are
//   posted into a small FIFO and drained to a slow peripheral bus over a
//   req/ack handshake. The CPU has no stall input, so posting lets it write to
//   slow peripherals without losing data. If the FIFO is full, the write is
//   dropped and a sticky overflow flag is raised.
//
// Ports:
//   clk       in   1         clock, rising edge
//   rst       in   1         asynchronous active-low reset
//   daddr     in   32        CPU data address
//   dout      in   32        CPU write data
//   drw       in   1         CPU write strobe (1 = write this cycle)
//   din       out  32        read data returned to the CPU
//   mem_addr  out  32        main-memory address (= daddr)
//   mem_dout  out  32        main-memory write data (= dout)
//   mem_drw   out  1         main-memory write strobe (suppressed inside window)
//   mem_din   in   32        main-memory read data
//   pb_req    out  1         peripheral request, held until pb_ack
//   pb_addr   out  WIN_BITS  peripheral offset of the head entry
//   pb_data   out  32        peripheral data of the head entry
//   pb_ack    in   1         peripheral accept, one-cycle pulse
//   irq_ovf   out  1         sticky overflow flag (mirrors STATUS[31])
//
// STATUS register (window offset 0):
//   {ovf, full, empty, 21'b0, level zero-extended to 8 bits}
//   Reading it returns the current state. Writing it clears ovf.
// -----------------------------------------------------------------------------
module cpu_wpost_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'hf000_0000,
    parameter int          WIN_BITS  = 12,
    parameter int          DEPTH     = 4,
    parameter int          LW        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         daddr,
    input  logic [31:0]         dout,
    input  logic                drw,
    output logic [31:0]         din,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_dout,
    output logic                mem_drw,
    input  logic [31:0]         mem_din,
    output logic                pb_req,
    output logic [WIN_BITS-1:0] pb_addr,
    output logic [31:0]         pb_data,
    input  logic                pb_ack,
    output logic                irq_ovf
);

    // Storage index width: the pointers carry one extra wrap bit on top of it.
    localparam int AW = LW - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_e;

    logic [WIN_BITS-1:0] offset;
    logic                win;
    logic                wrEvent;
    logic                clrOvf;
    logic                pushReq;
    logic                pushOk;
    logic                drop;
    logic                pop;

    logic [LW-1:0]       wrPtr_q, wrPtr_d;
    logic [LW-1:0]       rdPtr_q, rdPtr_d;
    logic [LW-1:0]       level;
    logic                full;
    logic                empty;
    logic                ovf_q, ovf_d;
    logic [31:0]         status;

    logic [WIN_BITS-1:0] fifoAddr_q [DEPTH];
    logic [31:0]         fifoData_q [DEPTH];

    state_e              state_q;
    logic                pbReq_q;
    logic [WIN_BITS-1:0] pbAddr_q;
    logic [31:0]         pbData_q;

    // Window decode and classification of the CPU access this cycle. A write
    // to offset 0 targets STATUS and clears ovf. Every other window write is
    // a posted write that goes into the FIFO.
    always_comb begin
        offset  = daddr[WIN_BITS-1:0];
        win     = (daddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
        wrEvent = drw & win;
        clrOvf  = wrEvent & (offset == '0);
        pushReq = wrEvent & (offset != '0);
    end

    // The pass-through to main memory stays purely combinational, so it keeps
    // working while the bridge is held in reset.
    always_comb begin
        mem_addr = daddr;
        mem_dout = dout;
        mem_drw  = drw & ~win;
    end

    // FIFO bookkeeping. Because the pointers wrap modulo 2*DEPTH, the
    // difference between them can tell full apart from empty. When the FIFO
    // is full, a pop in the same cycle frees the head slot, so the push is
    // still accepted. Without that pop, the write is lost and ovf is raised.
    // If a clear and a drop happen together, ovf ends up set.
    always_comb begin
        level   = wrPtr_q - rdPtr_q;
        full    = (level == LW'(DEPTH));
        empty   = (level == '0);
        pop     = pbReq_q & pb_ack;
        pushOk  = pushReq & (~full | pop);
        drop    = pushReq & full & ~pop;

        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + LW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + LW'(1);
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clrOvf) begin
            ovf_d = 1'b0;
        end
    end

    // Read mux. Inside the window, only offset 0 (STATUS) returns data.
    always_comb begin
        status = {ovf_q, full, empty, 21'b0, {(8-LW){1'b0}}, level};
        if (!win) begin
            din = mem_din;
        end else if (offset == '0) begin
            din = status;
        end else begin
            din = 32'h0;
        end
    end

    // Pointer and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage. Its contents do not matter after reset, so it has no
    // reset. An accepted push while full overwrites the slot being popped in
    // that same cycle. This is safe because the head was already copied into
    // the pb_* registers.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoAddr_q[wrPtr_q[AW-1:0]] <= offset;
            fifoData_q[wrPtr_q[AW-1:0]] <= dout;
        end
    end

    // Drain FSM. The head entry is copied into the pb_* registers when the
    // FSM enters REQ, so the request stays stable for the whole handshake.
    // After each accepted transfer, one GAP cycle forces pb_req low, which
    // keeps consecutive requests at least three cycles apart. pb_ack is
    // ignored outside REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pbReq_q  <= 1'b0;
            pbAddr_q <= '0;
            pbData_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        state_q  <= ST_REQ;
                        pbReq_q  <= 1'b1;
                        pbAddr_q <= fifoAddr_q[rdPtr_q[AW-1:0]];
                        pbData_q <= fifoData_q[rdPtr_q[AW-1:0]];
                    end
                end
                ST_REQ: begin
                    if (pb_ack) begin
                        state_q <= ST_GAP;
                        pbReq_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    pbReq_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    pbReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign pb_req  = pbReq_q;
    assign pb_addr = pbAddr_q;
    assign pb_data = pbData_q;
    assign irq_ovf = ovf_q;

endmodule

// File: tb/tb_cpu_wpost_bridge.sv
// -----------------------------------------------------------------------------
// tb_cpu_wpost_bridge
//
// Self-checking bench for cpu_wpost_bridge. It keeps a queue-based reference
// model of the posted-write FIFO and the overflow flag. Directed scenarios run
// first, followed by a randomized mix of CPU accesses and peripheral acks.
// -----------------------------------------------------------------------------
module tb_cpu_wpost_bridge;

    localparam logic [31:0] BASE  = 32'hf000_0000;
    localparam int          DEPTH = 4;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_0100;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] daddr;
    logic [31:0] dout;
    logic        drw;
    logic [31:0] din;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        mem_drw;
    logic [31:0] mem_din;
    logic        pb_req;
    logic [11:0] pb_addr;
    logic [31:0] pb_data;
    logic        pb_ack;
    logic        irq_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: the posted entries in order, plus the sticky flag.
    entry_t q[$];
    bit     mOvf = 1'b0;

    cpu_wpost_bridge #(
        .BASE_ADDR(BASE),
        .WIN_BITS (12),
        .DEPTH    (DEPTH),
        .LW       (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .daddr   (daddr),
        .dout    (dout),
        .drw     (drw),
        .din     (din),
        .mem_addr(mem_addr),
        .mem_dout(mem_dout),
        .mem_drw (mem_drw),
        .mem_din (mem_din),
        .pb_req  (pb_req),
        .pb_addr (pb_addr),
        .pb_data (pb_data),
        .pb_ack  (pb_ack),
        .irq_ovf (irq_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] expStatus();
        int n;
        n = q.size();
        return {mOvf, (n == DEPTH), (n == 0), 21'b0, 8'(n)};
    endfunction

    // Advance one clock edge and apply the FIFO rules to the model, using the
    // inputs that were present before the edge.
    task automatic step();
        bit w, clr, push, pop, isFull;
        entry_t e;
        w      = drw && (daddr[31:12] == BASE[31:12]);
        clr    = w && (daddr[11:0] == 12'h0);
        push   = w && !clr;
        pop    = pb_ack && pb_req && (q.size() > 0);
        isFull = (q.size() == DEPTH);
        e.a    = daddr[11:0];
        e.d    = dout;
        @(posedge clk);
        if (push && isFull && !pop) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        if (pop) void'(q.pop_front());
        if (push && (!isFull || pop)) q.push_back(e);
        #1;
    endtask

    task automatic driveIdle();
        drw   = 1'b0;
        daddr = IDLE_ADDR;
        dout  = 32'h0;
    endtask

    task automatic winWrite(input logic [11:0] off, input logic [31:0] data);
        drw   = 1'b1;
        daddr = BASE | {20'h0, off};
        dout  = data;
        step();
        driveIdle();
    endtask

    task automatic waitReq(output bit ok);
        ok = pb_req;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = pb_req;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        driveIdle();
        pb_ack  = 1'b0;
        mem_din = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pb_req !== 1'b0 || irq_ovf !== 1'b0 || pb_addr !== 12'h0 || pb_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b ovf=%b addr=%h data=%h, expected all zero",
                     pb_req, irq_ovf, pb_addr, pb_data);
        end
        daddr = BASE;
        #1;
        checks++;
        if (din !== 32'h2000_0000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected %h", din, 32'h2000_0000);
        end
        driveIdle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        daddr = IDLE_ADDR;
        dout  = 32'h1234;
        drw   = 1'b1;
        #1;
        checks++;
        if (mem_drw !== 1'b1 || mem_addr !== IDLE_ADDR || mem_dout !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL passthru_write: got drw=%b addr=%h data=%h expected 1/%h/%h",
                     mem_drw, mem_addr, mem_dout, IDLE_ADDR, 32'h1234);
        end
        step();
        checks++;
        if (pb_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL passthru_no_req: got pb_req=%b expected 0", pb_req);
        end
        drw     = 1'b0;
        mem_din = 32'hCAFE;
        #1;
        checks++;
        if (din !== 32'hCAFE) begin
            errors++;
            $display("[TB] FAIL passthru_read: got %h expected %h", din, 32'hCAFE);
        end
        daddr = BASE | 32'h10;
        #1;
        checks++;
        if (din !== 32'h0) begin
            errors++;
            $display("[TB] FAIL window_read_nonstatus: got %h expected 0", din);
        end
        driveIdle();
    endtask

    task automatic test_single_post();
        drw   = 1'b1;
        daddr = BASE | 32'h8;
        dout  = 32'hA5;
        #1;
        checks++;
        if (mem_drw !== 1'b0) begin
            errors++;
            $display("[TB] FAIL window_mem_drw: got %b expected 0", mem_drw);
        end
        step();
        driveIdle();
        daddr = BASE;
        #1;
        checks++;
        if (din !== 32'h0000_0001 || din !== expStatus()) begin
            errors++;
            $display("[TB] FAIL post_status: got %h expected %h", din, 32'h0000_0001);
        end
        checks++;
        if (pb_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_req_early: got %b expected 0", pb_req);
        end
        driveIdle();
        step();
        checks++;
        if (pb_req !== 1'b1 || pb_addr !== 12'h008 || pb_data !== 32'hA5) begin
            errors++;
            $display("[TB] FAIL post_req: got req=%b addr=%h data=%h expected 1/008/000000a5",
                     pb_req, pb_addr, pb_data);
        end
        repeat (5) step();
        checks++;
        if (pb_req !== 1'b1 || pb_addr !== 12'h008 || pb_data !== 32'hA5) begin
            errors++;
            $display("[TB] FAIL post_req_held: got req=%b addr=%h data=%h expected 1/008/000000a5",
                     pb_req, pb_addr, pb_data);
        end
        pb_ack = 1'b1;
        step();
        pb_ack = 1'b0;
        daddr  = BASE;
        #1;
        checks++;
        if (pb_req !== 1'b0 || din !== 32'h2000_0000) begin
            errors++;
            $display("[TB] FAIL post_popped: got req=%b status=%h expected 0/20000000", pb_req, din);
        end
        driveIdle();
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cnt;
        winWrite(12'h040, 32'h1111_0040);
        winWrite(12'h044, 32'h1111_0044);
        waitReq(ok);
        pb_ack = 1'b1;
        step();
        pb_ack = 1'b0;
        cnt = 0;
        while (!pb_req && cnt < 10) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt !== 2 || pb_addr !== 12'h044 || pb_data !== 32'h1111_0044 || !ok) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got gap=%0d addr=%h expected gap=2 addr=044", cnt, pb_addr);
        end
        pb_ack = 1'b1;
        step();
        pb_ack = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_fill_overflow();
        logic [11:0] expA [4];
        bit ok;
        expA = '{12'h004, 12'h008, 12'h00C, 12'h010};
        pb_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            winWrite(12'(4 * (i + 1)), 32'hD000_0000 + 32'(i));
        end
        daddr = BASE;
        #1;
        checks++;
        if (din !== 32'hC000_0004 || irq_ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fill_status: got %h irq=%b expected c0000004 irq=1", din, irq_ovf);
        end
        driveIdle();
        for (int i = 0; i < 4; i++) begin
            waitReq(ok);
            checks++;
            if (!ok || pb_addr !== expA[i] || pb_data !== 32'hD000_0000 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL drain_%0d: got req=%b addr=%h data=%h expected addr=%h",
                         i, ok, pb_addr, pb_data, expA[i]);
            end
            pb_ack = 1'b1;
            step();
            pb_ack = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pb_req) ok = 1'b1;
        end
        daddr = BASE;
        #1;
        checks++;
        if (ok || din !== 32'hA000_0000) begin
            errors++;
            $display("[TB] FAIL drain_done: got extra_req=%b status=%h expected 0/a0000000", ok, din);
        end
        driveIdle();
    endtask

    task automatic test_overflow_clear();
        winWrite(12'h000, 32'hFFFF_FFFF);
        daddr = BASE;
        #1;
        checks++;
        if (din[31] !== 1'b0 || irq_ovf !== 1'b0 || din !== expStatus()) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got status=%h irq=%b expected %h irq=0", din, irq_ovf, expStatus());
        end
        driveIdle();
    endtask

    task automatic test_push_pop_full();
        logic [11:0] expA [4];
        bit ok;
        expA = '{12'h024, 12'h028, 12'h02C, 12'h030};
        pb_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            winWrite(12'h020 + 12'(4 * i), 32'hB000_0020 + 32'(4 * i));
        end
        waitReq(ok);
        pb_ack = 1'b1;
        drw    = 1'b1;
        daddr  = BASE | 32'h30;
        dout   = 32'hB000_0030;
        step();
        pb_ack = 1'b0;
        driveIdle();
        daddr = BASE;
        #1;
        checks++;
        if (!ok || din !== 32'h4000_0004 || irq_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pushpop_full: got status=%h irq=%b expected 40000004 irq=0", din, irq_ovf);
        end
        driveIdle();
        for (int i = 0; i < 4; i++) begin
            waitReq(ok);
            checks++;
            if (!ok || pb_addr !== expA[i] || pb_data !== 32'hB000_0024 + 32'(4 * i)) begin
                errors++;
                $display("[TB] FAIL pushpop_drain_%0d: got req=%b addr=%h data=%h expected addr=%h",
                         i, ok, pb_addr, pb_data, expA[i]);
            end
            pb_ack = 1'b1;
            step();
            pb_ack = 1'b0;
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        pb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            winWrite(12'h100 + 12'(4 * i), 32'hE000_0000 + 32'(i));
        end
        waitReq(ok);
        daddr = BASE;
        #1;
        checks++;
        if (!ok || din !== 32'h0000_0003) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: got req=%b status=%h expected 1/00000003", ok, din);
        end
        driveIdle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (pb_req !== 1'b0 || pb_addr !== 12'h0 || pb_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got req=%b addr=%h data=%h expected 0/0/0",
                     pb_req, pb_addr, pb_data);
        end
        q.delete();
        mOvf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ok  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pb_req) ok = 1'b1;
        end
        daddr = BASE;
        #1;
        checks++;
        if (ok || din !== 32'h2000_0000) begin
            errors++;
            $display("[TB] FAIL rstmid_after: got spurious_req=%b status=%h expected 0/20000000", ok, din);
        end
        driveIdle();
        winWrite(12'h200, 32'h0BAD_F00D);
        waitReq(ok);
        checks++;
        if (!ok || pb_addr !== 12'h200 || pb_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL rstmid_resume: got req=%b addr=%h data=%h expected 1/200/0badf00d",
                     ok, pb_addr, pb_data);
        end
        pb_ack = 1'b1;
        step();
        pb_ack = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r       = $urandom_range(0, 9);
            mem_din = $urandom;
            dout    = $urandom;
            if (pb_req) pb_ack = 1'($urandom_range(0, 1));
            else        pb_ack = ($urandom_range(0, 3) == 0);
            if (r < 5) begin
                drw   = 1'b1;
                daddr = BASE | 32'($urandom_range(1, 4095));
            end else if (r == 5) begin
                drw   = 1'b1;
                daddr = BASE;
            end else if (r == 6) begin
                drw   = 1'b1;
                daddr = 32'($urandom_range(0, 32'h0fff_ffff));
            end else begin
                drw   = 1'b0;
                daddr = BASE;
            end
            #1;
            checks++;
            if (pb_req && q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rand_req_empty: cycle %0d got pb_req=1 expected 0", cyc);
            end else if (pb_req && (pb_addr !== q[0].a || pb_data !== q[0].d)) begin
                errors++;
                $display("[TB] FAIL rand_head: cycle %0d got %h/%h expected %h/%h",
                         cyc, pb_addr, pb_data, q[0].a, q[0].d);
            end
            checks++;
            if (irq_ovf !== mOvf || mem_drw !== (r == 6)) begin
                errors++;
                $display("[TB] FAIL rand_flags: cycle %0d got irq=%b mem_drw=%b expected %b/%b",
                         cyc, irq_ovf, mem_drw, mOvf, (r == 6));
            end
            if (r >= 7) begin
                checks++;
                if (din !== expStatus()) begin
                    errors++;
                    $display("[TB] FAIL rand_status: cycle %0d got %h expected %h", cyc, din, expStatus());
                end
            end
            step();
        end
        driveIdle();
        pb_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_single_post();
        test_back_to_back();
        test_fill_overflow();
        test_overflow_clear();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
